// File: rtl/stv_onehot_to_bin_pipe_if.sv
// stv_onehot_to_bin_pipe_if: one-hot converter bus; slave = converter, master = driver/observer. Carries in_valid/in_ready/in_onehot, out_valid/out_ready/out_bin/out_zero/out_multi, err_clear/err_count.
interface stv_onehot_to_bin_pipe_if #(
  parameter int ONEHOT_WIDTH  = 8,
  parameter int NUM_LANES     = 1,
  parameter int ERR_CNT_WIDTH = 16
);
  localparam int BIN_WIDTH = (ONEHOT_WIDTH == 1) ? 1 : $clog2(ONEHOT_WIDTH);
  logic                                     in_valid;
  logic                                     in_ready;
  logic [NUM_LANES-1:0][ONEHOT_WIDTH-1:0]   in_onehot;
  logic                                     out_valid;
  logic                                     out_ready;
  logic [NUM_LANES-1:0][BIN_WIDTH-1:0]      out_bin;
  logic [NUM_LANES-1:0]                     out_zero;
  logic [NUM_LANES-1:0]                     out_multi;
  logic                                     err_clear;
  logic [ERR_CNT_WIDTH-1:0]                 err_count;
  modport master (
    output in_valid, in_onehot, out_ready, err_clear,
    input  in_ready, out_valid, out_bin, out_zero, out_multi, err_count
  );
  modport slave (
    input  in_valid, in_onehot, out_ready, err_clear,
    output in_ready, out_valid, out_bin, out_zero, out_multi, err_count
  );
endinterface

// File: rtl/stv_onehot_to_bin_pipe.sv
// stv_onehot_to_bin_pipe: registered multi-lane one-hot to binary converter with skid buffer and saturating malformed-beat counter; ports clk, rst (sync, active high), bus (slave side of stv_onehot_to_bin_pipe_if).
module stv_onehot_to_bin_pipe #(
  parameter int ONEHOT_WIDTH  = 8,
  parameter int NUM_LANES     = 1,
  parameter int PRIORITY_MODE = 0,
  parameter int ERR_CNT_WIDTH = 16
) (
  input logic clk,
  input logic rst,
  stv_onehot_to_bin_pipe_if.slave bus
);
  localparam int BIN_WIDTH = (ONEHOT_WIDTH == 1) ? 1 : $clog2(ONEHOT_WIDTH);
  logic [NUM_LANES-1:0][BIN_WIDTH-1:0] enc_bin, skid_bin, out_bin_q;
  logic [NUM_LANES-1:0]                enc_zero, enc_multi, skid_zero, skid_multi, out_zero_q, out_multi_q;
  logic                                out_valid_q, rdy_q, in_fire, drain;
  logic [ERR_CNT_WIDTH-1:0]            err_q;
  assign in_fire = bus.in_valid && rdy_q;
  assign drain = !out_valid_q || bus.out_ready;
  assign bus.in_ready = rdy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_bin = out_bin_q;
  assign bus.out_zero = out_zero_q;
  assign bus.out_multi = out_multi_q;
  assign bus.err_count = err_q;
  // Scan high to low so that in priority mode the lowest set bit is written last.
  always_comb begin
    enc_bin = '0;
    enc_zero = '0;
    enc_multi = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      enc_zero[l] = bus.in_onehot[l] == '0;
      enc_multi[l] = |(bus.in_onehot[l] & (bus.in_onehot[l] - ONEHOT_WIDTH'(1)));
      for (int j = ONEHOT_WIDTH - 1; j >= 0; j--)
        if (bus.in_onehot[l][j]) enc_bin[l] = (PRIORITY_MODE != 0) ? BIN_WIDTH'(j) : enc_bin[l] | BIN_WIDTH'(j);
    end
  end
  // rdy_q doubles as the "skid entry empty" flag, so in_ready comes straight off a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      rdy_q <= 1'b1;
      out_bin_q <= '0;
      out_zero_q <= '0;
      out_multi_q <= '0;
      skid_bin <= '0;
      skid_zero <= '0;
      skid_multi <= '0;
      err_q <= '0;
    end else begin
      if (drain) begin
        out_valid_q <= !rdy_q || in_fire;
        rdy_q <= 1'b1;
        if (!rdy_q) {out_bin_q, out_zero_q, out_multi_q} <= {skid_bin, skid_zero, skid_multi};
        else if (in_fire) {out_bin_q, out_zero_q, out_multi_q} <= {enc_bin, enc_zero, enc_multi};
      end else if (in_fire) begin
        {skid_bin, skid_zero, skid_multi} <= {enc_bin, enc_zero, enc_multi};
        rdy_q <= 1'b0;
      end
      err_q <= bus.err_clear ? '0 : (in_fire && |enc_multi && !(&err_q)) ? err_q + ERR_CNT_WIDTH'(1) : err_q;
    end
  end
`ifdef ASSERT_ON
  if (ONEHOT_WIDTH < 1 || NUM_LANES < 1 || ERR_CNT_WIDTH < 1) begin : g_bad_param
    $error("stv_onehot_to_bin_pipe: illegal parameters");
  end
  a_stable: assert property (@(posedge clk) disable iff (rst)
    out_valid_q && !bus.out_ready |=> out_valid_q && $stable(out_bin_q) && $stable(out_zero_q) && $stable(out_multi_q));
`endif
endmodule

// File: tb/tb_stv_onehot_to_bin_pipe.sv
// tb_stv_onehot_to_bin_pipe: table-driven and sequence checks of the one-hot to binary pipe in three configurations.
module tb_stv_onehot_to_bin_pipe;
  logic clk = 1'b0;
  logic rst, in_valid, out_ready, err_clear;
  logic [7:0] l1, l0;
  int n_cmp = 0, n_err = 0, cnt16 = 0, cnt2 = 0;
  always #5 clk = ~clk;
  stv_onehot_to_bin_pipe_if #(.ONEHOT_WIDTH(8), .NUM_LANES(2), .ERR_CNT_WIDTH(16)) b0 ();
  stv_onehot_to_bin_pipe_if #(.ONEHOT_WIDTH(8), .NUM_LANES(2), .ERR_CNT_WIDTH(2)) b1 ();
  stv_onehot_to_bin_pipe_if #(.ONEHOT_WIDTH(1), .NUM_LANES(1), .ERR_CNT_WIDTH(4)) b2 ();
  assign b0.in_valid = in_valid;
  assign b0.in_onehot = {l1, l0};
  assign b0.out_ready = out_ready;
  assign b0.err_clear = err_clear;
  assign b1.in_valid = in_valid;
  assign b1.in_onehot = {l1, l0};
  assign b1.out_ready = out_ready;
  assign b1.err_clear = err_clear;
  assign b2.in_valid = in_valid;
  assign b2.in_onehot = l0[0];
  assign b2.out_ready = out_ready;
  assign b2.err_clear = err_clear;
  stv_onehot_to_bin_pipe #(.ONEHOT_WIDTH(8), .NUM_LANES(2), .PRIORITY_MODE(0), .ERR_CNT_WIDTH(16)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  stv_onehot_to_bin_pipe #(.ONEHOT_WIDTH(8), .NUM_LANES(2), .PRIORITY_MODE(1), .ERR_CNT_WIDTH(2)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  stv_onehot_to_bin_pipe #(.ONEHOT_WIDTH(1), .NUM_LANES(1), .PRIORITY_MODE(0), .ERR_CNT_WIDTH(4)) dut2 (.clk(clk), .rst(rst), .bus(b2));
  typedef struct {
    logic [7:0] l1, l0;
    logic [2:0] b1, b0, p1, p0;
    logic [1:0] z, m;
  } vec_t;
  vec_t tv [9];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [7:0] a1, input logic [7:0] a0);
    in_valid = v;
    l1 = a1;
    l0 = a0;
  endtask
  initial begin
    tv[0] = '{8'h80, 8'h01, 3'd7, 3'd0, 3'd7, 3'd0, 2'b00, 2'b00};
    tv[1] = '{8'h80, 8'h01, 3'd7, 3'd0, 3'd7, 3'd0, 2'b00, 2'b00};
    tv[2] = '{8'h01, 8'h80, 3'd0, 3'd7, 3'd0, 3'd7, 2'b00, 2'b00};
    tv[3] = '{8'h00, 8'h06, 3'd0, 3'd3, 3'd0, 3'd1, 2'b10, 2'b01};
    tv[4] = '{8'h06, 8'h06, 3'd3, 3'd3, 3'd1, 3'd1, 2'b00, 2'b11};
    tv[5] = '{8'h00, 8'h00, 3'd0, 3'd0, 3'd0, 3'd0, 2'b11, 2'b00};
    tv[6] = '{8'hff, 8'h10, 3'd7, 3'd4, 3'd0, 3'd4, 2'b00, 2'b10};
    tv[7] = '{8'h24, 8'h08, 3'd7, 3'd3, 3'd2, 3'd3, 2'b00, 2'b10};
    tv[8] = '{8'h40, 8'h02, 3'd6, 3'd1, 3'd6, 3'd1, 2'b00, 2'b00};
    rst = 1'b1;
    out_ready = 1'b1;
    err_clear = 1'b0;
    drive(1'b0, 8'h00, 8'h00);
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_out_valid", b0.out_valid, 0);
    chk("rst_in_ready", b0.in_ready, 1);
    chk("rst_out_bin", b0.out_bin, 0);
    chk("rst_zero_multi", {b0.out_zero, b0.out_multi}, 0);
    chk("rst_err", b0.err_count, 0);
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, tv[i].l1, tv[i].l0);
      tick();
      cnt16 += (tv[i].m != 0) ? 1 : 0;
      cnt2 = (tv[i].m != 0 && cnt2 < 3) ? cnt2 + 1 : cnt2;
      chk($sformatf("v%0d_valid", i), b0.out_valid, 1);
      chk($sformatf("v%0d_in_ready", i), b0.in_ready, 1);
      chk($sformatf("v%0d_bin_pm0", i), b0.out_bin, {tv[i].b1, tv[i].b0});
      chk($sformatf("v%0d_bin_pm1", i), b1.out_bin, {tv[i].p1, tv[i].p0});
      chk($sformatf("v%0d_zero", i), b0.out_zero, tv[i].z);
      chk($sformatf("v%0d_multi", i), b0.out_multi, tv[i].m);
      chk($sformatf("v%0d_multi_pm1", i), b1.out_multi, tv[i].m);
      chk($sformatf("v%0d_err16", i), b0.err_count, cnt16);
      chk($sformatf("v%0d_err2", i), b1.err_count, cnt2);
      chk($sformatf("v%0d_w1", i), {b2.out_bin, b2.out_zero, b2.out_multi}, {1'b0, !tv[i].l0[0], 1'b0});
    end
    drive(1'b0, 8'h00, 8'h00);
    tick();
    chk("idle_valid", b0.out_valid, 0);
    drive(1'b1, 8'h04, 8'h01);
    tick();
    chk("bp_a_out", {b0.out_valid, b0.out_bin}, {1'b1, 3'd2, 3'd0});
    out_ready = 1'b0;
    drive(1'b1, 8'h10, 8'h20);
    tick();
    chk("bp_a_held", {b0.out_valid, b0.out_bin}, {1'b1, 3'd2, 3'd0});
    chk("bp_skid_ready", b0.in_ready, 0);
    drive(1'b1, 8'h03, 8'h03);
    tick();
    chk("bp_a_held2", {b0.out_valid, b0.out_bin}, {1'b1, 3'd2, 3'd0});
    chk("bp_ready_low", b0.in_ready, 0);
    chk("bp_err_no_accept", b0.err_count, cnt16);
    drive(1'b0, 8'h00, 8'h00);
    out_ready = 1'b1;
    tick();
    chk("bp_b_out", {b0.out_valid, b0.out_bin}, {1'b1, 3'd4, 3'd5});
    chk("bp_ready_back", b0.in_ready, 1);
    tick();
    chk("bp_drained", b0.out_valid, 0);
    drive(1'b1, 8'h06, 8'h06);
    err_clear = 1'b1;
    tick();
    chk("clr_err16", b0.err_count, 0);
    chk("clr_err2", b1.err_count, 0);
    err_clear = 1'b0;
    cnt16 = 0;
    cnt2 = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      cnt16++;
      cnt2 = (cnt2 < 3) ? cnt2 + 1 : 3;
      chk($sformatf("sat%0d_err2", i), b1.err_count, cnt2);
      chk($sformatf("sat%0d_err16", i), b0.err_count, cnt16);
    end
    out_ready = 1'b0;
    drive(1'b1, 8'h01, 8'h02);
    tick();
    drive(1'b1, 8'h02, 8'h04);
    tick();
    chk("full_ready", b0.in_ready, 0);
    drive(1'b0, 8'h00, 8'h00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    chk("mid_rst_valid", b0.out_valid, 0);
    chk("mid_rst_ready", b0.in_ready, 1);
    chk("mid_rst_err", b0.err_count, 0);
    drive(1'b1, 8'h08, 8'h40);
    tick();
    chk("post_rst_beat", {b0.out_valid, b0.out_bin}, {1'b1, 3'd3, 3'd6});
    drive(1'b0, 8'h00, 8'h00);
    tick();
    chk("post_rst_idle", b0.out_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/stv_onehot_to_bin_pipe.md
Name: stv_onehot_to_bin_pipe

Overview:
Registered, multi-lane successor to the combinational one-hot to binary converter. Converts NUM_LANES one-hot vectors per beat to unsigned binary indices behind a valid/ready handshake with a skid buffer. Flags zero and multi-hot lanes, and keeps a saturating count of malformed beats. Sits between arbiters or grant logic and downstream index-consuming pipelines where timing needs a flop boundary.

Parameters:
ONEHOT_WIDTH, 8, bits per one-hot lane; must be >= 1.
NUM_LANES, 1, number of independent lanes converted per beat; must be >= 1.
PRIORITY_MODE, 0, selects multi-hot handling. 0 = OR of the indices of all set bits; 1 = index of the lowest set bit.
ERR_CNT_WIDTH, 16, width of the malformed-beat counter.
BIN_WIDTH (localparam), derived: 1 if ONEHOT_WIDTH == 1, else $clog2(ONEHOT_WIDTH).

Ports:
clk  input  1  clock; all state on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  input beat valid.
in_ready  output  1  block can accept a beat; driven from a flop.
in_onehot  input  [NUM_LANES][ONEHOT_WIDTH]  one-hot vectors, one per lane.
out_valid  output  1  output beat valid.
out_ready  input  1  downstream accepts the beat.
out_bin  output  [NUM_LANES][BIN_WIDTH]  binary index per lane.
out_zero  output  [NUM_LANES]  lane input was all zeros.
out_multi  output  [NUM_LANES]  lane input had more than one bit set.
err_clear  input  1  synchronous clear of err_count.
err_count  output  ERR_CNT_WIDTH  saturating count of accepted beats with any out_multi lane set.

Behaviour:
- Reset: out_valid=0, in_ready=1, out_bin/out_zero/out_multi=0, err_count=0, skid buffer empty. Reset mid-transfer discards all held beats; no partial output follows.
- Handshake:
  - Input transfer occurs on in_valid && in_ready; output transfer on out_valid && out_ready.
  - out_valid must not depend combinationally on out_ready.
  - Held output data is stable while out_valid && !out_ready.
- Latency: 1 cycle. A beat accepted in cycle N appears on the outputs in cycle N+1 if the output register is empty or draining.
- Storage: output register plus one skid entry, two beats total.
  - in_ready = !skid_valid, registered.
  - Accepting a beat while the output is stalled writes it to the skid entry. in_ready drops the next cycle.
  - When the output drains, the skid entry moves to the output register and in_ready rises the following cycle.
  - Full throughput: one beat per cycle with out_ready held high.
- Encoding per lane, computed before the output register:
  - zero = (lane == 0). When zero is set, bin = 0 in both modes.
  - multi = more than one bit set.
  - PRIORITY_MODE 0: bin bit i = OR over set bits j of j[i]. For a legal one-hot input this equals the index.
  - PRIORITY_MODE 1: bin = lowest set index.
- ONEHOT_WIDTH == 1: bin is always 0, multi is never set, zero = !lane.
- Error counter:
  - Increments by 1 on each input transfer where any lane has multi set.
  - Zero lanes do not count.
  - Saturates at all-ones; no wrap.
  - err_clear has priority: a clear in the same cycle as a counted transfer yields 0.
- Lanes are independent. One lane's errors never alter another lane's bin.
- Assertions (ASSERT_ON only): parameter legality; out_valid && !out_ready implies stable outputs next cycle.

Test Plan:
- ONEHOT_WIDTH=8, NUM_LANES=2, out_ready=1: send lanes {8'h01, 8'h80} for 4 consecutive beats -> out_bin={0,7} each cycle, 1-cycle latency, in_ready stays 1, zero/multi=0.
- Backpressure: out_ready=0 after beat A is output, send B -> B lands in the skid entry and in_ready=0 the next cycle. Raise out_ready -> A, then B in consecutive cycles; in_ready returns to 1; no beat lost or duplicated.
- Multi-hot: lane 8'h06 with PRIORITY_MODE=0 -> bin=3, multi=1. With PRIORITY_MODE=1 -> bin=1, multi=1. err_count increments by 1 per beat, even if both lanes are multi-hot.
- Zero input: lane 8'h00 -> bin=0, zero=1, multi=0, err_count unchanged.
- Counter: ERR_CNT_WIDTH=2, 5 multi-hot beats -> err_count 1,2,3,3,3. err_clear asserted together with a multi-hot beat -> err_count=0.
- Reset mid-operation: rst asserted with both entries full -> next cycle out_valid=0, in_ready=1, err_count=0. The first beat after reset emerges with 1-cycle latency.
